peripheral_noc_router_input_route: RTL

Router input stage: receives flits from one physical link carrying VCHANNELS virtual channels and buffers each VC in its own FIFO. It decodes the destination field of each packet's header flit through a static route table and forwards the packet to one of OUTPUTS router output ports. It is the receive-side counterpart of the router output stage: its per-VC/per-output `out_*` bundle feeds the per-VC/per-input `in_*` bundle of the output stages through the switch wiring.

---
 rtl/peripheral_noc_router_input_route.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/peripheral_noc_router_input_route.sv
// NoC router input stage: per-VC FIFOs, header route lookup and per-output valid steering.
// Optional PERIPHERAL_NOC_ROUTE_ERROR_EN: unroutable packets are drained and flagged instead of sent to output 0.
module peripheral_noc_router_input_route #(
  parameter int FLIT_WIDTH   = 32,
  parameter int VCHANNELS    = 7,
  parameter int OUTPUTS      = 7,
  parameter int DESTS        = 8,
  parameter logic [DESTS*OUTPUTS-1:0] ROUTES = '0,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [FLIT_WIDTH-1:0]                 in_flit,
  input  logic                                  in_last,
  input  logic [VCHANNELS-1:0]                  in_valid,
  output logic [VCHANNELS-1:0]                  in_ready,
  output logic [VCHANNELS-1:0][FLIT_WIDTH-1:0]  out_flit,
  output logic [VCHANNELS-1:0]                  out_last,
  output logic [VCHANNELS-1:0][OUTPUTS-1:0]     out_valid,
  input  logic [VCHANNELS-1:0][OUTPUTS-1:0]     out_ready,
  output logic [VCHANNELS-1:0]                  route_error
);

  localparam int DEST_WIDTH = (DESTS > 1) ? $clog2(DESTS) : 1;
  localparam int PTR_W      = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CNT_W      = $clog2(BUFFER_DEPTH + 1);

`ifdef PERIPHERAL_NOC_ROUTE_ERROR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1} state_t;
`endif

  // Destinations outside the table resolve to an all-zero (unroutable) entry.
  function automatic logic [OUTPUTS-1:0] route_lookup(input logic [DEST_WIDTH-1:0] dest);
    logic [OUTPUTS-1:0] entry;
    entry = '0;
    for (int d = 0; d < DESTS; d++)
      if (DEST_WIDTH'(d) == dest) entry = ROUTES[d*OUTPUTS +: OUTPUTS];
    return entry;
  endfunction

  function automatic logic [OUTPUTS-1:0] lowest_bit(input logic [OUTPUTS-1:0] vec);
    logic [OUTPUTS-1:0] res;
    logic               found;
    res   = '0;
    found = 1'b0;
    for (int o = 0; o < OUTPUTS; o++)
      if (vec[o] && !found) begin
        res[o] = 1'b1;
        found  = 1'b1;
      end
    return res;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  for (genvar v = 0; v < VCHANNELS; v++) begin : g_vc
    logic [FLIT_WIDTH:0]  mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    state_t               state;
    logic [OUTPUTS-1:0]   sel, route;
    logic [FLIT_WIDTH:0]  head;
    logic                 nonempty, push, pop;

    assign head        = mem[rd_ptr];
    assign nonempty    = (count != '0);
    assign in_ready[v] = (count < CNT_W'(BUFFER_DEPTH));
    assign push        = in_valid[v] && in_ready[v];
    assign out_flit[v] = head[FLIT_WIDTH-1:0];
    assign out_last[v] = head[FLIT_WIDTH];
    assign out_valid[v] = (state == ACTIVE && nonempty) ? sel : '0;
    assign route       = lowest_bit(route_lookup(head[FLIT_WIDTH-1 -: DEST_WIDTH]));

`ifdef PERIPHERAL_NOC_ROUTE_ERROR_EN
    logic err;
    assign route_error[v] = err;
    assign pop = (state == ACTIVE) ? |(out_valid[v] & out_ready[v]) :
                 (state == DRAIN)  ? nonempty : 1'b0;
`else
    assign route_error[v] = 1'b0;
    assign pop = (state == ACTIVE) && |(out_valid[v] & out_ready[v]);
`endif

    // FIFO storage is data only and needs no reset.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_last, in_flit};
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        state  <= IDLE;
        sel    <= '0;
`ifdef PERIPHERAL_NOC_ROUTE_ERROR_EN
        err    <= 1'b0;
`endif
      end else begin
`ifdef PERIPHERAL_NOC_ROUTE_ERROR_EN
        err <= 1'b0;
`endif
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);

        case (state)
          IDLE: begin
            if (nonempty) begin
              if (route != '0) begin
                sel   <= route;
                state <= ACTIVE;
              end else begin
`ifdef PERIPHERAL_NOC_ROUTE_ERROR_EN
                sel   <= '0;
                state <= DRAIN;
                err   <= 1'b1;
`else
                sel   <= OUTPUTS'(1);
                state <= ACTIVE;
`endif
              end
            end
          end
          ACTIVE: if (pop && head[FLIT_WIDTH]) state <= IDLE;
`ifdef PERIPHERAL_NOC_ROUTE_ERROR_EN
          DRAIN:  if (pop && head[FLIT_WIDTH]) state <= IDLE;
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
